// File: rtl/crc32_seq_pkg.sv
// rtl/crc32_seq_pkg.sv - shared types and constants for the CRC32 frame sequencer
package crc32_seq_pkg;

  localparam int CRC_WORD_W    = 32;
  localparam int CRC_BLK_W     = 256;
  localparam int WORDS_PER_BLK = 8;

  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/crc32_blk_packer.sv
// rtl/crc32_blk_packer.sv - packs 32-bit words into a zero-padded 256-bit engine block
module crc32_blk_packer
  import crc32_seq_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic                  start,
  input  logic [CRC_WORD_W-1:0] wr_data,
  input  logic                  wr_last,
  output logic [CRC_BLK_W-1:0]  blk_data,
  output logic                  blk_done,
  output logic                  blk_last,
  output logic                  blk_pad
);

  logic [2:0]           word_cnt;
  logic [2:0]           slot;
  logic [CRC_BLK_W-1:0] blk_next;

  // A frame's first word always lands in slot 0 of a fresh block.
  assign slot     = start ? 3'd0 : word_cnt;
  assign blk_done = wr_en && (wr_last || (slot == 3'(WORDS_PER_BLK - 1)));

  always_comb begin
    blk_next = start ? '0 : blk_data;
    blk_next[{slot, 5'd0} +: CRC_WORD_W] = wr_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      blk_data <= '0;
      word_cnt <= '0;
      blk_last <= 1'b0;
      blk_pad  <= 1'b0;
    end else if (wr_en) begin
      blk_data <= blk_next;
      word_cnt <= slot + 3'd1;
      blk_last <= wr_last;
      blk_pad  <= wr_last && (slot != 3'(WORDS_PER_BLK - 1));
    end
  end

endmodule

// File: rtl/crc32_frame_sequencer.sv
// rtl/crc32_frame_sequencer.sv - sequences an external 256-bit CRC32 engine over word-stream frames
// CRC32_SEQ_FINAL_XOR_EN: when defined, crc_o carries the inverted chain state.
module crc32_frame_sequencer
  import crc32_seq_pkg::*;
#(
  parameter logic [31:0] CRC_INIT       = 32'hFFFFFFFF,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter int          BLK_CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [CRC_WORD_W-1:0] s_data_i,
  input  logic                  s_valid_i,
  input  logic                  s_last_i,
  output logic                  s_ready_o,
  output logic                  eng_en_o,
  output logic [CRC_BLK_W-1:0]  eng_data_o,
  output logic [31:0]           eng_state_o,
  input  logic [31:0]           eng_state_i,
  input  logic                  eng_valid_i,
  output logic [31:0]           crc_o,
  output logic                  crc_valid_o,
  input  logic                  crc_ready_i,
  output logic                  crc_pad_o,
  output logic [BLK_CNT_W-1:0]  blk_cnt_o,
  output logic                  err_o
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  seq_state_e  state;
  logic [31:0] chain;
  logic [7:0]  tcnt;
  logic        frame_last;
  logic        pad_lat;
  logic        accept;
  logic        pk_clear;
  logic        pk_done;
  logic        pk_last;
  logic        pk_pad;
  logic        timed_out;
  logic [31:0] crc_final;

  assign accept      = s_valid_i && s_ready_o;
  assign eng_state_o = chain;
  assign timed_out   = (state == ST_WAIT) && !eng_valid_i && (tcnt == TO_LAST);
  assign pk_clear    = ((state == ST_WAIT) && eng_valid_i && !frame_last) || timed_out;

`ifdef CRC32_SEQ_FINAL_XOR_EN
  assign crc_final = ~eng_state_i;
`else
  assign crc_final = eng_state_i;
`endif

  crc32_blk_packer u_packer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear    (pk_clear),
    .wr_en    (accept),
    .start    (state == ST_IDLE),
    .wr_data  (s_data_i),
    .wr_last  (s_last_i),
    .blk_data (eng_data_o),
    .blk_done (pk_done),
    .blk_last (pk_last),
    .blk_pad  (pk_pad)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      s_ready_o   <= 1'b0;
      eng_en_o    <= 1'b0;
      chain       <= CRC_INIT;
      crc_o       <= '0;
      crc_valid_o <= 1'b0;
      crc_pad_o   <= 1'b0;
      blk_cnt_o   <= '0;
      err_o       <= 1'b0;
      tcnt        <= '0;
      frame_last  <= 1'b0;
      pad_lat     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          s_ready_o <= 1'b1;
          if (accept) begin
            chain     <= CRC_INIT;
            blk_cnt_o <= '0;
            if (pk_done) begin
              state     <= ST_ISSUE;
              s_ready_o <= 1'b0;
              eng_en_o  <= 1'b1;
            end else begin
              state <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (pk_done) begin
            state     <= ST_ISSUE;
            s_ready_o <= 1'b0;
            eng_en_o  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          eng_en_o   <= 1'b0;
          tcnt       <= 8'd1;
          frame_last <= pk_last;
          pad_lat    <= pk_pad;
          if (blk_cnt_o != {BLK_CNT_W{1'b1}}) begin
            blk_cnt_o <= blk_cnt_o + {{(BLK_CNT_W-1){1'b0}}, 1'b1};
          end
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A result arriving on the final timeout cycle still wins.
          if (eng_valid_i) begin
            chain <= eng_state_i;
            if (frame_last) begin
              state       <= ST_DONE;
              crc_valid_o <= 1'b1;
              crc_o       <= crc_final;
              crc_pad_o   <= pad_lat;
            end else begin
              state     <= ST_FILL;
              s_ready_o <= 1'b1;
            end
          end else if (timed_out) begin
            err_o     <= 1'b1;
            state     <= ST_IDLE;
            s_ready_o <= 1'b1;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        ST_DONE: begin
          if (crc_ready_i) begin
            crc_valid_o <= 1'b0;
            crc_pad_o   <= 1'b0;
            state       <= ST_IDLE;
            s_ready_o   <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          s_ready_o <= 1'b0;
          eng_en_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc32_frame_sequencer.sv
// tb/tb_crc32_frame_sequencer.sv - scoreboard bench for crc32_frame_sequencer (honours CRC32_SEQ_FINAL_XOR_EN)
module tb_crc32_frame_sequencer;
  import crc32_seq_pkg::*;

  localparam logic [31:0] INIT = 32'hFFFFFFFF;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic [31:0]  s_data_i = '0;
  logic         s_valid_i = 1'b0;
  logic         s_last_i = 1'b0;
  logic         s_ready_o;
  logic         eng_en_o;
  logic [255:0] eng_data_o;
  logic [31:0]  eng_state_o;
  logic [31:0]  eng_state_i = '0;
  logic         eng_valid_i = 1'b0;
  logic [31:0]  crc_o;
  logic         crc_valid_o;
  logic         crc_ready_i = 1'b1;
  logic         crc_pad_o;
  logic [15:0]  blk_cnt_o;
  logic         err_o;

  always #5 clk = ~clk;

  crc32_frame_sequencer dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .s_data_i    (s_data_i),
    .s_valid_i   (s_valid_i),
    .s_last_i    (s_last_i),
    .s_ready_o   (s_ready_o),
    .eng_en_o    (eng_en_o),
    .eng_data_o  (eng_data_o),
    .eng_state_o (eng_state_o),
    .eng_state_i (eng_state_i),
    .eng_valid_i (eng_valid_i),
    .crc_o       (crc_o),
    .crc_valid_o (crc_valid_o),
    .crc_ready_i (crc_ready_i),
    .crc_pad_o   (crc_pad_o),
    .blk_cnt_o   (blk_cnt_o),
    .err_o       (err_o)
  );

  typedef struct { logic [31:0] st; logic [255:0] data; } issue_t;
  typedef struct { logic [31:0] crc; logic pad; logic [15:0] nblk; } frame_t;

  issue_t exp_issue[$];
  frame_t exp_frame[$];
  issue_t mon_i;
  frame_t mon_f;

  int n_checks = 0;
  int n_pass = 0;
  int eng_mode = 0;       // 0: fixed 0x12345678, 1: mixing function, 2: never answers
  int eng_lat = 3;
  bit eng_lat_rand = 1'b0;
  int rdy_mode = 0;       // 0: always ready, 1: random, 2: driven by the main sequence

  logic [255:0] eng_d;
  logic [31:0]  eng_r;
  int           eng_l;

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic logic [31:0] eng_fn(int mode, logic [31:0] st, logic [255:0] blk);
    logic [31:0] h;
    h = st;
    if (mode == 0) return 32'h12345678;
    for (int i = 0; i < 8; i++) begin
      h = {h[30:0], 1'b0} ^ (h[31] ? CRC32_POLY : 32'h0) ^ blk[i*32 +: 32];
    end
    return h;
  endfunction

  function automatic logic [31:0] final_xor(logic [31:0] st);
`ifdef CRC32_SEQ_FINAL_XOR_EN
    return ~st;
`else
    return st;
`endif
  endfunction

  // Reference: split into 8-word blocks, zero-fill the tail, chain the engine state.
  task automatic expect_frame(input logic [31:0] w[$], input bit completes);
    logic [31:0]  st;
    logic [255:0] blk;
    int           nb;
    st = INIT;
    nb = (w.size() + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      blk = '0;
      for (int i = 0; i < 8; i++) begin
        if (b*8 + i < w.size()) blk[i*32 +: 32] = w[b*8 + i];
      end
      exp_issue.push_back('{st, blk});
      st = eng_fn(eng_mode, st, blk);
    end
    if (completes) exp_frame.push_back('{final_xor(st), (w.size() % 8) != 0, 16'(nb)});
  endtask

  task automatic send_words(input logic [31:0] w[$], input bit with_last, input int gap_max);
    bit acc;
    int guard;
    for (int i = 0; i < w.size(); i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        s_valid_i = 1'b0;
        s_last_i  = 1'($urandom_range(0, 1));
        s_data_i  = $urandom;
        @(posedge clk); #1;
      end
      s_valid_i = 1'b1;
      s_data_i  = w[i];
      s_last_i  = with_last && (i == w.size() - 1);
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 500) begin
        @(negedge clk);
        acc = s_ready_o;
        @(posedge clk); #1;
        guard++;
      end
      if (!acc) chk("accept_wait", 256'(acc), 256'(1));
    end
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] w[$], input int gap_max);
    expect_frame(w, 1'b1);
    send_words(w, 1'b1, gap_max);
  endtask

  task automatic wait_idle(input int budget);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!(exp_frame.size() == 0 && exp_issue.size() == 0 && s_ready_o && !crc_valid_o) && g < budget);
    if (g >= budget) chk("idle_wait", 256'(g), 256'(0));
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_s_ready"}, 256'(s_ready_o), 256'(0));
    chk({tag, "_eng_en"}, 256'(eng_en_o), 256'(0));
    chk({tag, "_eng_state"}, 256'(eng_state_o), 256'(INIT));
    chk({tag, "_eng_data"}, eng_data_o, 256'(0));
    chk({tag, "_crc_valid"}, 256'(crc_valid_o), 256'(0));
    chk({tag, "_crc"}, 256'(crc_o), 256'(0));
    chk({tag, "_crc_pad"}, 256'(crc_pad_o), 256'(0));
    chk({tag, "_blk_cnt"}, 256'(blk_cnt_o), 256'(0));
    chk({tag, "_err"}, 256'(err_o), 256'(0));
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) crc_ready_i = 1'($urandom_range(0, 1));
    else if (rdy_mode == 0) crc_ready_i = 1'b1;
  end

  // Monitor: every engine enable and every CRC handshake pops the scoreboard.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (eng_en_o) begin
        chk("ready_low_in_issue", 256'(s_ready_o), 256'(0));
        chk("issue_expected", 256'(exp_issue.size() > 0), 256'(1));
        if (exp_issue.size() > 0) begin
          mon_i = exp_issue.pop_front();
          chk("issue_state", 256'(eng_state_o), 256'(mon_i.st));
          chk("issue_data", eng_data_o, mon_i.data);
        end
      end
      if (crc_valid_o && crc_ready_i) begin
        chk("ready_low_in_done", 256'(s_ready_o), 256'(0));
        chk("frame_expected", 256'(exp_frame.size() > 0), 256'(1));
        if (exp_frame.size() > 0) begin
          mon_f = exp_frame.pop_front();
          chk("crc", 256'(crc_o), 256'(mon_f.crc));
          chk("crc_pad", 256'(crc_pad_o), 256'(mon_f.pad));
          chk("blk_cnt", 256'(blk_cnt_o), 256'(mon_f.nblk));
        end
      end
    end
  end

  // Engine model: answers eng_l cycles after the enable with a single-cycle valid.
  always begin
    @(negedge clk);
    if (eng_en_o && !rst_i && eng_mode != 2) begin
      eng_d = eng_data_o;
      eng_r = eng_fn(eng_mode, eng_state_o, eng_data_o);
      eng_l = eng_lat_rand ? int'($urandom_range(1, 6)) : eng_lat;
      repeat (eng_l) @(posedge clk);
      #1;
      eng_valid_i = 1'b1;
      eng_state_i = eng_r;
      @(negedge clk);
      chk("data_stable_in_wait", eng_data_o, eng_d);
      chk("ready_low_in_wait", 256'(s_ready_o), 256'(0));
      @(posedge clk); #1;
      eng_valid_i = 1'b0;
      eng_state_i = $urandom;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w[$];
    logic [31:0] held;
    int g;
    int n;

    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst_i = 1'b0;

    eng_mode = 0; eng_lat = 3;
    w = {};
    for (int i = 0; i < 8; i++) w.push_back(32'(i));
    run_frame(w, 0);
    wait_idle(300);

    eng_mode = 1;
    w = {};
    for (int i = 0; i < 19; i++) w.push_back($urandom);
    run_frame(w, 1);
    wait_idle(500);

    w = {32'hDEADBEEF};
    run_frame(w, 0);
    wait_idle(300);

    rdy_mode = 2;
    crc_ready_i = 1'b0;
    w = {};
    for (int i = 0; i < 5; i++) w.push_back($urandom);
    run_frame(w, 0);
    g = 0;
    do begin @(negedge clk); g++; end while (!crc_valid_o && g < 200);
    chk("stall_valid_seen", 256'(crc_valid_o), 256'(1));
    held = crc_o;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid_held", 256'(crc_valid_o), 256'(1));
      chk("stall_crc_held", 256'(crc_o), 256'(held));
      chk("stall_ready_low", 256'(s_ready_o), 256'(0));
    end
    @(posedge clk); #1;
    crc_ready_i = 1'b1;
    @(posedge clk); #1;
    rdy_mode = 0;
    @(negedge clk);
    chk("release_valid_low", 256'(crc_valid_o), 256'(0));
    chk("release_idle_ready", 256'(s_ready_o), 256'(1));
    wait_idle(100);

    eng_lat = 63;
    w = {};
    for (int i = 0; i < 8; i++) w.push_back($urandom);
    run_frame(w, 0);
    wait_idle(300);
    chk("late_valid_no_err", 256'(err_o), 256'(0));
    eng_lat = 3;

    rdy_mode = 1;
    eng_lat_rand = 1'b1;
    for (int f = 0; f < 15; f++) begin
      n = $urandom_range(1, 30);
      w = {};
      for (int i = 0; i < n; i++) w.push_back($urandom);
      run_frame(w, 2);
    end
    wait_idle(5000);
    rdy_mode = 0;
    eng_lat_rand = 1'b0;

    eng_mode = 2;
    w = {};
    for (int i = 0; i < 3; i++) w.push_back($urandom);
    expect_frame(w, 1'b0);
    send_words(w, 1'b1, 0);
    g = 0;
    do begin @(negedge clk); g++; end while (!eng_en_o && g < 50);
    n = 0;
    while (!err_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycle", 256'(n), 256'(64));
    chk("timeout_err", 256'(err_o), 256'(1));
    chk("timeout_idle", 256'(s_ready_o), 256'(1));
    chk("timeout_no_crc", 256'(crc_valid_o), 256'(0));
    @(posedge clk); #1;
    eng_mode = 1;

    w = {};
    for (int i = 0; i < 5; i++) w.push_back($urandom);
    send_words(w, 1'b0, 0);
    rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("midframe_reset");
    @(posedge clk); #1;
    rst_i = 1'b0;
    w = {};
    for (int i = 0; i < 8; i++) w.push_back($urandom);
    run_frame(w, 0);
    wait_idle(300);

    chk("issues_drained", 256'(exp_issue.size()), 256'(0));
    chk("frames_drained", 256'(exp_frame.size()), 256'(0));
    chk("final_err", 256'(err_o), 256'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
